// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared bus constants and the target memory FSM state type.
package serial_bus_pkg;
    localparam int BUS_ADDR_WIDTH = 16;
    localparam int BUS_DATA_WIDTH = 8;
    localparam logic [3:0] TARGET3_BASE = 4'b1000;
    typedef enum logic [2:0] {
        IDLE, WR_WAIT_DATA, WR_ACK, RD_WAIT, SPLIT_WAIT, RD_RESP
    } tmem_state_t;
endpackage

// File: rtl/target_mem_array.sv
// target_mem_array: single-port synchronous RAM; the read register updates only on re and holds otherwise.
module target_mem_array #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    always_ff @(posedge clk)
        if (we) mem_q[addr] <= wdata;
    always_comb rdata_d = re ? mem_q[addr] : rdata_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata_q <= '0;
        else rdata_q <= rdata_d;
    assign rdata = rdata_q;
endmodule

// File: rtl/serial_target_mem.sv
// serial_target_mem: byte memory core behind the split target port (slave 3).
// Define TARGET_MEM_SPLIT_EN to answer long-latency reads through the split request/grant path.
module serial_target_mem #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 8,
    parameter int READ_LATENCY    = 2,
    parameter int SPLIT_THRESHOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           target_addr_in,
    input  logic                  target_addr_in_valid,
    input  logic [DATA_WIDTH-1:0] target_data_in,
    input  logic                  target_data_in_valid,
    input  logic                  target_rw_in,
    output logic [DATA_WIDTH-1:0] target_data_out,
    output logic                  target_data_out_valid,
    output logic                  target_ready,
    output logic                  target_ack,
    output logic                  split_req,
    input  logic                  split_grant
);
    import serial_bus_pkg::*;
    localparam int CW = $clog2(READ_LATENCY + 2);
`ifdef TARGET_MEM_SPLIT_EN
    localparam bit USE_SPLIT = READ_LATENCY >= SPLIT_THRESHOLD;
`else
    localparam bit USE_SPLIT = 1'b0;
`endif
    // A split read leaves the countdown one cycle early so split_req is up in the final wait cycle.
    localparam logic [CW-1:0] CNT_LOAD = USE_SPLIT ? CW'(READ_LATENCY - 1) : CW'(READ_LATENCY);

    tmem_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic ready_q, ready_d, we, re;
    logic addr_hi_unused;

    assign addr_hi_unused = ^target_addr_in[15:ADDR_WIDTH];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        case (state_q)
            IDLE:
                if (target_addr_in_valid) begin
                    addr_d = target_addr_in[ADDR_WIDTH-1:0];
                    if (target_rw_in) begin
                        we      = target_data_in_valid;
                        state_d = target_data_in_valid ? WR_ACK : WR_WAIT_DATA;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = (READ_LATENCY == 0) ? RD_RESP : RD_WAIT;
                    end
                end
            WR_WAIT_DATA:
                if (target_data_in_valid) begin
                    we      = 1'b1;
                    state_d = WR_ACK;
                end
            RD_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = USE_SPLIT ? SPLIT_WAIT : RD_RESP;
            end
            SPLIT_WAIT: state_d = split_grant ? RD_RESP : SPLIT_WAIT;
            default: state_d = IDLE;
        endcase
        re       = (state_d == RD_RESP);
        ready_d  = (state_d == IDLE);
        mem_addr = (state_q == IDLE) ? target_addr_in[ADDR_WIDTH-1:0] : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end

    target_mem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .re    (re),
        .addr  (mem_addr),
        .wdata (target_data_in),
        .rdata (target_data_out)
    );

    assign target_ready          = ready_q;
    assign target_ack            = (state_q == WR_ACK);
    assign target_data_out_valid = (state_q == RD_RESP);
    assign split_req             = (state_q == SPLIT_WAIT);
endmodule

// File: tb/tb_serial_target_mem.sv
// tb_serial_target_mem: scoreboard bench for serial_target_mem with default parameters.
module tb_serial_target_mem;
    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] addr_in;
    logic addr_v, rw, data_v, grant;
    logic [7:0] data_in, data_out;
    logic data_out_v, ready, ack, sreq;

    logic [7:0] exp_q[$];
    int n_checks = 0, n_pass = 0, n_valid = 0, v0;
    logic split_seen = 1'b0;

    always #5 clk = ~clk;

    serial_target_mem dut (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr_in), .target_addr_in_valid(addr_v),
        .target_data_in(data_in), .target_data_in_valid(data_v),
        .target_rw_in(rw),
        .target_data_out(data_out), .target_data_out_valid(data_out_v),
        .target_ready(ready), .target_ack(ack),
        .split_req(sreq), .split_grant(grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic av, input logic [15:0] a, input logic w, input logic dv, input logic [7:0] d);
        addr_v = av; addr_in = a; rw = w; data_v = dv; data_in = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] e);
        drive(1, a, 0, 0, 8'h00);
        exp_q.push_back(e);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        if (sreq) split_seen = 1'b1;
        if (data_out_v) begin
            n_valid++;
            if (exp_q.size() == 0) check("rd_unexpected", exp_q.size(), 1);
            else check("rd_data", data_out, exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0; grant = 1'b0;
        drive(0, 16'h0, 0, 0, 8'h00);
        step(); step();
        check("rst_ready", ready, 0);
        check("rst_ack", ack, 0);
        check("rst_valid", data_out_v, 0);
        check("rst_sreq", sreq, 0);
        check("rst_dout", data_out, 0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", ready, 1);
        // write with address and data together
        drive(1, 16'h800A, 1, 1, 8'h5C);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        check("t1_ack_n1", ack, 1);
        check("t1_ready_n1", ready, 0);
        step();
        check("t1_ack_n2", ack, 0);
        check("t1_ready_n2", ready, 1);
        // read back immediately; data_valid alongside a read must be ignored
        drive(1, 16'h800A, 0, 1, 8'hFF);
        exp_q.push_back(8'h5C);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        check("t2_valid_n1", data_out_v, 0);
        step();
        check("t2_valid_n2", data_out_v, 0);
        step();
        check("t2_valid_n3", data_out_v, 1);
        check("t2_ready_n3", ready, 0);
        step();
        check("t2_valid_n4", data_out_v, 0);
        check("t2_hold_n4", data_out, 8'h5C);
        check("t2_ready_n4", ready, 1);
        // write with data arriving three cycles after the address
        drive(1, 16'h8F44, 1, 0, 8'h00);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        check("t3_ack_n1", ack, 0);
        check("t3_ready_n1", ready, 0);
        step();
        check("t3_ack_n2", ack, 0);
        step();
        drive(0, 16'h0, 0, 1, 8'hA7);
        check("t3_ack_n3", ack, 0);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        check("t3_ack_n4", ack, 1);
        step();
        check("t3_ack_n5", ack, 0);
        check("t3_ready_n5", ready, 1);
        do_read(16'h0F44, 8'hA7);
        // commands during the read countdown are ignored
        drive(1, 16'h800A, 0, 0, 8'h00);
        exp_q.push_back(8'h5C);
        step();
        drive(1, 16'h8F44, 0, 0, 8'h00);
        step();
        drive(1, 16'h8F44, 1, 1, 8'h11);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        check("t4_valid_n3", data_out_v, 1);
        step();
        check("t4_valid_n4", data_out_v, 0);
        do_read(16'h8F44, 8'hA7);
        // reset during a read aborts it but keeps memory
        drive(1, 16'h8123, 1, 1, 8'h3C);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        step();
        drive(1, 16'h8123, 0, 0, 8'h00);
        step();
        drive(0, 16'h0, 0, 0, 8'h00);
        rst_n = 1'b0;
        #1;
        check("t5_ready", ready, 0);
        check("t5_ack", ack, 0);
        check("t5_valid", data_out_v, 0);
        check("t5_sreq", sreq, 0);
        check("t5_dout", data_out, 0);
        v0 = n_valid;
        step(); step();
        rst_n = 1'b1;
        repeat (5) step();
        check("t5_no_valid", n_valid, v0);
        check("t5_ready_back", ready, 1);
        do_read(16'h8123, 8'h3C);
        step(); step();
        check("q_empty", exp_q.size(), 0);
        check("n_valid", n_valid, 5);
        check("split_req_never", split_seen, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
